// File: rtl/packet_wr_arbiter_pkg.sv
// Shared definitions for the trace packet buffer write side: word width,
// packet size default and write-scheduler state encoding.
package packet_wr_arbiter_pkg;

   localparam int unsigned WORD_W        = 16;
   localparam int unsigned PKT_WORDS_DEF = 8;

   localparam logic [1:0] ST_FLUSH  = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   // Index width for n items, never below one bit.
   function automatic int unsigned idxWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/packet_wr_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request bit at or above ptr,
// wrapping around to bit 0.
module packet_wr_arbiter_rr_pick
   import packet_wr_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_SRC = 2,
   localparam int unsigned IDX_W   = idxWidth(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   int unsigned cand;

   // Scan from the farthest offset down so the nearest hit wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         cand = 32'(ptr) + 32'(i);
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (req[cand[IDX_W-1:0]]) begin
            idx   = cand[IDX_W-1:0];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/packet_wr_arbiter.sv
// Write-side scheduler for the trace packet buffer: round-robin grant locked
// per packet, with flush on abort, timeout and after reset.
module packet_wr_arbiter
   import packet_wr_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_SRC   = 2,
   parameter  int unsigned PKT_WORDS = PKT_WORDS_DEF,
   parameter  int unsigned TIMEOUT   = 255,
   parameter  int unsigned CNT_W     = 16,
   localparam int unsigned IDX_W     = idxWidth(NUM_SRC)
) (
   input  logic                      wrClk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [WORD_W*NUM_SRC-1:0] src_wd,
   input  logic [NUM_SRC-1:0]        src_abort,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      WdAvail,
   output logic [WORD_W-1:0]         PacketWd,
   output logic                      PacketReset,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy,
   output logic [CNT_W-1:0]          abort_count
);

   localparam int unsigned WCNT_W = idxWidth(PKT_WORDS);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

   logic [1:0]        state, stateNxt;
   logic [IDX_W-1:0]  rrPtr, rrPtrNxt;
   logic [WCNT_W-1:0] wordCnt, wordCntNxt;
   logic [TO_W-1:0]   toCnt, toCntNxt;
   logic [IDX_W-1:0]  grantNxt;
   logic              wdAvailNxt, packetResetNxt, busyNxt;
   logic [WORD_W-1:0] packetWdNxt;
   logic [CNT_W-1:0]  abortCntNxt;

   logic [WORD_W-1:0] srcWord [NUM_SRC];
   logic [IDX_W-1:0]  pickIdx, nextPtr;
   logic              pickFound, grantAbort, xfer, timedOut, lastWord;

   for (genvar i = 0; i < NUM_SRC; i++) begin : gWord
      assign srcWord[i] = src_wd[WORD_W*i +: WORD_W];
   end

   packet_wr_arbiter_rr_pick #(.NUM_SRC(NUM_SRC)) uPick (
      .req   (src_valid),
      .ptr   (rrPtr),
      .idx   (pickIdx),
      .found (pickFound)
   );

   assign grantAbort = src_abort[grant_id];
   assign xfer       = src_ready[grant_id] && src_valid[grant_id];
   assign timedOut   = !xfer && (toCnt == TO_W'(TIMEOUT - 1));
   assign lastWord   = (wordCnt == WCNT_W'(PKT_WORDS - 1));
   assign nextPtr    = (grant_id == IDX_W'(NUM_SRC - 1)) ? '0 : grant_id + IDX_W'(1);

   // Only the granted source is ever accepted; its own abort blocks the word.
   always_comb begin
      src_ready = '0;
      if (state == ST_STREAM && !grantAbort) src_ready[grant_id] = 1'b1;
   end

   always_comb begin
      stateNxt       = state;
      rrPtrNxt       = rrPtr;
      wordCntNxt     = wordCnt;
      toCntNxt       = toCnt;
      grantNxt       = grant_id;
      wdAvailNxt     = 1'b0;
      packetWdNxt    = PacketWd;
      packetResetNxt = 1'b0;
      abortCntNxt    = abort_count;
      case (state)
         ST_FLUSH: begin
            packetResetNxt = 1'b1;
            stateNxt       = ST_IDLE;
         end
         ST_IDLE: begin
            if (pickFound) begin
               grantNxt   = pickIdx;
               wordCntNxt = '0;
               toCntNxt   = '0;
               stateNxt   = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (grantAbort || timedOut) begin
               // Abort and timeout together still cost only one flush and one count.
               stateNxt    = ST_FLUSH;
               rrPtrNxt    = nextPtr;
               abortCntNxt = (&abort_count) ? abort_count : abort_count + CNT_W'(1);
            end else if (xfer) begin
               wdAvailNxt  = 1'b1;
               packetWdNxt = srcWord[grant_id];
               toCntNxt    = '0;
               if (lastWord) begin
                  stateNxt   = ST_IDLE;
                  rrPtrNxt   = nextPtr;
                  wordCntNxt = '0;
               end else begin
                  wordCntNxt = wordCnt + WCNT_W'(1);
               end
            end else begin
               toCntNxt = toCnt + TO_W'(1);
            end
         end
         default: stateNxt = ST_FLUSH;
      endcase
      busyNxt = (stateNxt == ST_STREAM);
   end

   always_ff @(posedge wrClk) begin
      if (rst) begin
         state       <= ST_FLUSH;
         rrPtr       <= '0;
         wordCnt     <= '0;
         toCnt       <= '0;
         grant_id    <= '0;
         WdAvail     <= 1'b0;
         PacketWd    <= '0;
         PacketReset <= 1'b0;
         busy        <= 1'b0;
         abort_count <= '0;
      end else begin
         state       <= stateNxt;
         rrPtr       <= rrPtrNxt;
         wordCnt     <= wordCntNxt;
         toCnt       <= toCntNxt;
         grant_id    <= grantNxt;
         WdAvail     <= wdAvailNxt;
         PacketWd    <= packetWdNxt;
         PacketReset <= packetResetNxt;
         busy        <= busyNxt;
         abort_count <= abortCntNxt;
      end
   end

endmodule

// File: tb/tb_packet_wr_arbiter.sv
// Directed and randomized bench for packet_wr_arbiter with two producers and
// a narrow abort counter so saturation is reachable.
module tb_packet_wr_arbiter;

   localparam int NSRC = 2;
   localparam int PW   = 8;
   localparam int TMO  = 255;
   localparam int CW   = 2;

   typedef logic [0:0] sid_t;

   logic            wrClk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src_valid, src_abort, src_ready;
   logic [16*NSRC-1:0] src_wd;
   logic            WdAvail, PacketReset, busy;
   logic [15:0]     PacketWd;
   logic [0:0]      grant_id;
   logic [CW-1:0]   abort_count;

   logic [15:0] cur [NSRC];
   sid_t        expPtr;
   int          expAborts;
   int          errors = 0;
   int          checks = 0;

   always #5 wrClk = ~wrClk;

   always_comb src_wd = {cur[1], cur[0]};

   packet_wr_arbiter #(
      .NUM_SRC(NSRC), .PKT_WORDS(PW), .TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .wrClk(wrClk), .rst(rst), .src_valid(src_valid), .src_wd(src_wd),
      .src_abort(src_abort), .src_ready(src_ready), .WdAvail(WdAvail),
      .PacketWd(PacketWd), .PacketReset(PacketReset), .grant_id(grant_id),
      .busy(busy), .abort_count(abort_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wrClk);
      #1;
   endtask

   // Saturating abort statistic as seen by a 2-bit counter.
   function automatic logic [31:0] expCnt();
      return (expAborts > 3) ? 32'd3 : 32'(expAborts);
   endfunction

   // Round-robin choice: first requesting source at or after the pointer.
   function automatic sid_t pick(input logic [NSRC-1:0] m, input sid_t p);
      sid_t c;
      for (int i = 0; i < NSRC; i++) begin
         c = sid_t'(32'(p) + 32'(i));
         if (m[c]) return c;
      end
      return p;
   endfunction

   task automatic grantStep(input sid_t g);
      tick();
      chk("grant_id", 32'(grant_id), 32'(g));
      chk("grant_busy", 32'(busy), 32'd1);
      chk("grant_wdavail", 32'(WdAvail), 32'd0);
      chk("grant_pktreset", 32'(PacketReset), 32'd0);
      chk("grant_ready", 32'(src_ready), 32'd1 << g);
   endtask

   // Granted source g offers n words, with random idle gaps and abort noise
   // on the other source; every offered word must appear one cycle later.
   task automatic sendWords(input sid_t g, input int n, input int unsigned maxGap, input bit inc);
      logic [15:0] w;
      for (int k = 0; k < n; k++) begin
         int unsigned gap;
         gap = (maxGap > 0) ? $urandom_range(maxGap, 0) : 0;
         for (int unsigned j = 0; j < gap; j++) begin
            src_valid[g] = 1'b0;
            src_abort = 2'($urandom);
            src_abort[g] = 1'b0;
            tick();
            chk("gap_wdavail", 32'(WdAvail), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
         end
         src_valid[g] = 1'b1;
         src_abort = 2'($urandom);
         src_abort[g] = 1'b0;
         w = cur[g];
         tick();
         chk("word_wdavail", 32'(WdAvail), 32'd1);
         chk("word_data", 32'(PacketWd), 32'(w));
         chk("word_pktreset", 32'(PacketReset), 32'd0);
         cur[g] = inc ? cur[g] + 16'd1 : 16'($urandom);
         if (n == PW && k == n - 1) begin
            chk("pkt_end_busy", 32'(busy), 32'd0);
            expPtr = sid_t'(32'(g) + 1);
         end
      end
      src_abort = '0;
   endtask

   // Abort the granted packet after n accepted words.
   task automatic abortAfter(input sid_t g, input int n);
      src_valid = '0;
      src_valid[g] = 1'b1;
      grantStep(pick(src_valid, expPtr));
      sendWords(g, n, 1, 1'b0);
      src_abort[g] = 1'b1;
      #1;
      chk("abort_ready_low", 32'(src_ready), 32'd0);
      tick();
      expAborts++;
      expPtr = sid_t'(32'(g) + 1);
      chk("abort_no_word", 32'(WdAvail), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_count", 32'(abort_count), expCnt());
      src_abort = '0;
      src_valid = '0;
      tick();
      chk("abort_flush", 32'(PacketReset), 32'd1);
      chk("abort_flush_wd", 32'(WdAvail), 32'd0);
   endtask

   initial begin
      sid_t g;
      rst = 1'b1;
      src_valid = '0;
      src_abort = '0;
      cur[0] = '0;
      cur[1] = '0;
      expPtr = '0;
      expAborts = 0;

      // Reset state and the single flush after release
      tick();
      tick();
      chk("rst_wdavail", 32'(WdAvail), 32'd0);
      chk("rst_pktreset", 32'(PacketReset), 32'd0);
      chk("rst_pktwd", 32'(PacketWd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_count", 32'(abort_count), 32'd0);
      rst = 1'b0;
      tick();
      chk("flush_pulse", 32'(PacketReset), 32'd1);
      chk("flush_wdavail", 32'(WdAvail), 32'd0);
      chk("flush_busy", 32'(busy), 32'd0);
      tick();
      chk("flush_single", 32'(PacketReset), 32'd0);

      // One back-to-back packet from src0
      cur[0] = 16'h1000;
      src_valid = 2'b01;
      grantStep(pick(src_valid, expPtr));
      sendWords(1'b0, PW, 0, 1'b1);
      src_valid = '0;
      tick();
      chk("idle_wdavail", 32'(WdAvail), 32'd0);
      chk("idle_count", 32'(abort_count), 32'd0);

      // Both sources continuously valid: grants alternate
      cur[0] = 16'($urandom);
      cur[1] = 16'($urandom);
      src_valid = 2'b11;
      for (int p = 0; p < 3; p++) begin
         g = pick(src_valid, expPtr);
         grantStep(g);
         sendWords(g, PW, 0, 1'b0);
      end
      src_valid = '0;

      // Timeout: src1 stalls after three words while src0 waits
      src_valid = 2'b10;
      grantStep(pick(src_valid, expPtr));
      sendWords(1'b1, 3, 0, 1'b0);
      src_valid = 2'b01;
      for (int i = 0; i < TMO - 1; i++) tick();
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_pktreset", 32'(PacketReset), 32'd0);
      tick();
      expAborts++;
      expPtr = 1'b0;
      chk("timeout_busy", 32'(busy), 32'd0);
      chk("timeout_count", 32'(abort_count), expCnt());
      tick();
      chk("timeout_flush", 32'(PacketReset), 32'd1);
      chk("timeout_flush_wd", 32'(WdAvail), 32'd0);
      grantStep(pick(src_valid, expPtr));
      sendWords(1'b0, PW, 3, 1'b0);
      src_valid = '0;

      // Abort on the last word, then drive the counter into saturation
      abortAfter(1'b0, PW - 1);
      abortAfter(1'b1, 2);
      abortAfter(1'b0, 0);
      chk("sat_count", 32'(abort_count), 32'd3);

      // Random producer mixes with gaps and foreign abort noise
      for (int p = 0; p < 6; p++) begin
         src_valid = 2'($urandom_range(3, 1));
         g = pick(src_valid, expPtr);
         grantStep(g);
         sendWords(g, PW, 2, 1'b0);
         src_valid = '0;
         chk("rand_count", 32'(abort_count), expCnt());
      end

      // Reset in mid-packet, then a clean packet
      src_valid = 2'b01;
      grantStep(pick(src_valid, expPtr));
      sendWords(1'b0, 4, 0, 1'b0);
      rst = 1'b1;
      src_valid = '0;
      tick();
      expAborts = 0;
      expPtr = '0;
      chk("mid_rst_wdavail", 32'(WdAvail), 32'd0);
      chk("mid_rst_pktwd", 32'(PacketWd), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_grant", 32'(grant_id), 32'd0);
      chk("mid_rst_count", 32'(abort_count), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_flush", 32'(PacketReset), 32'd1);
      tick();
      chk("post_rst_flush_end", 32'(PacketReset), 32'd0);
      cur[0] = 16'h2000;
      src_valid = 2'b11;
      grantStep(pick(src_valid, expPtr));
      sendWords(1'b0, PW, 0, 1'b1);
      src_valid = '0;
      tick();
      chk("final_wdavail", 32'(WdAvail), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
